sel_scan_ctrl: RTL and testbench
================================

Name: sel_scan_ctrl

Overview:
- Upstream control stage for the team's 4-to-1 selector; generates its 2-bit SEL so four request sources share one output path.
- Round-robin over REQ[3:0], with a programmable dwell time per grant, an early-release acknowledge and a grant lock.
- Registered SEL/VALID outputs drive the selector's SEL directly; VALID qualifies the selector output for the downstream consumer.

Parameters:
- DWELL, 4, cycles a granted channel holds SEL before rotating; legal 1..2^CNT_W-1.
- CNT_W, 4, width of the dwell counter.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- EN  input  1  scan enable; low forces idle.
- REQ  input  4  per-channel request; bit i requests channel i (i = SEL code).
- ACK  input  1  downstream done with current channel; releases grant early.
- LOCK  input  1  suppresses dwell expiry while high.
- SEL  output  2  channel select to the 4-to-1 selector.
- VALID  output  1  SEL is a live grant.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. With RST_N low at an edge: SEL=2'b00, VALID=0, state=IDLE, cnt=0, last-grant pointer=3 (first search starts at channel 0). This applies mid-grant too: the next cycle shows VALID=0.
- States: IDLE, GRANT.
- Search:
  - Start index is last+1 mod 4, wrapping, and includes last as the final candidate.
  - First set REQ bit in that rotated order wins.
  - found=0 if REQ==0.
- IDLE:
  - If EN=1 and found: next cycle GRANT, SEL=winner, VALID=1, cnt=DWELL-1, last=winner.
  - Else stay in IDLE, VALID=0, SEL holds its previous value.
  - Latency from REQ to VALID is 1 cycle.
- GRANT, release condition = (cnt==0 and LOCK=0) or ACK=1 or REQ[SEL]=0.
  - EN=0 takes priority: next cycle IDLE, VALID=0.
  - No release: stay in GRANT, SEL unchanged. cnt decrements if cnt!=0 and LOCK=0; it holds at 0 while LOCK=1.
  - Release with found: switch directly to the winner with no bubble. VALID stays 1, SEL=winner, cnt reloads to DWELL-1, last updated.
  - If the current channel is the only requester, it is re-granted and SEL is unchanged.
  - Release with no request: next cycle IDLE, VALID=0, SEL holds.
- Simultaneous events:
  - ACK together with expiry counts as one release.
  - LOCK does not block ACK or a dropped REQ.
  - REQ changing in the release cycle: the search uses the REQ value sampled in that same cycle.
- DWELL=1: each grant lasts exactly 1 cycle; round-robin rotates every cycle.
- Width rule: cnt is CNT_W bits and never underflows. DWELL outside 1..2^CNT_W-1 is illegal (elaboration assertion).
- SEL only changes on a grant; glitch-free since it is registered.

Decomposition:
- Shared package sel_pkg:
  - N_CH=4, SEL_W=2.
  - State enum {IDLE, GRANT}.
  - Reset constants SEL_RST=2'b00 and LAST_RST=2'd3.
- Sub-module rr_pick (combinational):
  - Inputs REQ[3:0], start[1:0]; outputs idx[1:0], found.
  - Rotate, priority-encode, unrotate.
  - Reused by any later arbiter in the codebase.

Test Plan:
- Reset, then EN=1, REQ=4'b0001 held, DWELL=4, ACK=0, LOCK=0 -> VALID rises the cycle after REQ; SEL=0 and VALID remain high continuously (re-granted every 4 cycles).
- REQ=4'b1111 held, DWELL=4 -> SEL sequence 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0; VALID never drops.
- REQ=4'b0101, ACK pulsed on the 2nd cycle of the channel-0 grant -> SEL=2 on the next cycle with cnt reloaded; channel 2 then holds 4 cycles.
- Grant on channel 1 with LOCK=1 for 10 cycles -> SEL stays 1 for all 10 cycles; after LOCK falls with cnt==0, SEL moves to the next requester the following cycle.
- Grant on channel 3, then REQ[3] drops with REQ=0 -> VALID=0 the next cycle and SEL holds 3; a later REQ=4'b1000 re-grants 3 after 1 cycle.
- RST_N low mid-grant (SEL=2), and separately EN low mid-grant -> the next cycle shows VALID=0. After reset SEL=0 and REQ=4'b1111 grants channel 0 first; after EN-low SEL holds 2.

Source files
------------

// File: rtl/sel_pkg.sv
// Shared definitions for the selector scan controller and its round-robin picker.
package sel_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SEL_RST  = 2'b00;
  localparam logic [SEL_W-1:0] LAST_RST = 2'd3;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after start, wrapping.
module rr_pick
  import sel_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;

  // rot[k] is the request k positions after start; the 2-bit sum wraps naturally
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
      assign rot[gi] = req[start + SEL_W'(gi)];
    end
  endgenerate

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = SEL_W'(k);
        found = 1'b1;
      end
    end
  end

  assign idx = start + off;

endmodule

// File: rtl/sel_scan_ctrl.sv
// Round-robin SEL generator for the 4-to-1 selector with dwell timer,
// early-release acknowledge and grant lock.
module sel_scan_ctrl
  import sel_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_CH-1:0]  req,
  input  logic             ack,
  input  logic             lock,
  output logic [SEL_W-1:0] sel,
  output logic             valid
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  generate
    if (DWELL < 1 || DWELL > (1 << CNT_W) - 1) begin : g_bad_dwell
      $error("sel_scan_ctrl: DWELL must be in 1..2^CNT_W-1");
    end
  endgenerate

  state_t           state_reg;
  logic [SEL_W-1:0] sel_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [SEL_W-1:0] last_reg;

  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] winner;
  logic             found;
  logic             rel_now;

  assign start = last_reg + SEL_W'(1);

  rr_pick u_pick (
    .req   (req),
    .start (start),
    .idx   (winner),
    .found (found)
  );

  // ACK, a dropped request and an unlocked expiry all collapse into one release
  assign rel_now = (cnt_reg == '0 && !lock) || ack || !req[sel_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_reg   <= SEL_RST;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
      last_reg  <= LAST_RST;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (en && found) begin
            state_reg <= GRANT;
            sel_reg   <= winner;
            valid_reg <= 1'b1;
            cnt_reg   <= CNT_LOAD;
            last_reg  <= winner;
          end else begin
            valid_reg <= 1'b0;
          end
        end
        GRANT: begin
          if (!en) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end else if (rel_now) begin
            if (found) begin
              sel_reg  <= winner;
              cnt_reg  <= CNT_LOAD;
              last_reg <= winner;
            end else begin
              state_reg <= IDLE;
              valid_reg <= 1'b0;
            end
          end else if (cnt_reg != '0 && !lock) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sel   = sel_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Directed bench for sel_scan_ctrl with a cycle-level reference model.
module tb_sel_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, ack, lock;
  logic [3:0] req;
  logic [1:0] sel;
  logic       valid;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  sel_scan_ctrl #(.DWELL(DWELL), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .ack   (ack),
    .lock  (lock),
    .sel   (sel),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Reference model: grant age in unlocked cycles, rotated search from the last winner
  logic [1:0] m_sel;
  logic       m_valid;
  int         m_last;
  int         m_used;

  function automatic logic [2:0] pick(input logic [3:0] r, input int last);
    int ch;
    for (int k = 1; k <= 4; k++) begin
      ch = (last + k) % 4;
      if (r[ch]) return {1'b1, 2'(ch)};
    end
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    logic [2:0] p;
    logic       expired;
    p = pick(req, m_last);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_sel   = 2'd0;
      m_last  = 3;
      m_used  = 0;
    end else if (!en) begin
      m_valid = 1'b0;
    end else if (!m_valid) begin
      if (p[2]) begin
        m_valid = 1'b1; m_sel = p[1:0]; m_last = int'(p[1:0]); m_used = 0;
      end
    end else begin
      expired = (m_used >= DWELL - 1) && !lock;
      if (expired || ack || !req[m_sel]) begin
        if (p[2]) begin
          m_sel = p[1:0]; m_last = int'(p[1:0]); m_used = 0;
        end else begin
          m_valid = 1'b0;
        end
      end else if (!lock) begin
        m_used = m_used + 1;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hand(input string name, input logic [1:0] exp_sel, input logic exp_valid);
    $display("%-14s sel=%0d valid=%0d (want sel=%0d valid=%0d)", name, sel, valid, exp_sel, exp_valid);
    check({name, ".sel"}, 8'(sel), 8'(exp_sel));
    check({name, ".valid"}, 8'(valid), 8'(exp_valid));
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("cmp_valid", 8'(valid), 8'(m_valid));
      check("cmp_sel", 8'(sel), 8'(m_sel));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0; ack = 1'b0; lock = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  int exp_seq [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 4'b0; ack = 1'b0; lock = 1'b0;
    step(2);
    hand("reset", 2'd0, 1'b0);
    rst_n = 1'b1;
    started = 1'b1;

    // single requester is re-granted without a gap
    en = 1'b1; req = 4'b0001;
    step(1);
    hand("t1_first", 2'd0, 1'b1);
    step(8);
    hand("t1_held", 2'd0, 1'b1);

    // full rotation with all channels requesting
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      step(1);
      hand($sformatf("t2_rr%0d", i), 2'(exp_seq[i]), 1'b1);
    end

    // ACK on 2nd grant cycle of channel 0 hands over to channel 2
    do_reset();
    req = 4'b0101;
    step(1);
    hand("t3_g0", 2'd0, 1'b1);
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    hand("t3_ack", 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      hand("t3_hold2", 2'd2, 1'b1);
    end
    step(1);
    hand("t3_back0", 2'd0, 1'b1);

    // LOCK holds an expired grant on channel 1
    do_reset();
    req = 4'b0110;
    step(1);
    hand("t4_g1", 2'd1, 1'b1);
    step(3);
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      hand("t4_locked", 2'd1, 1'b1);
    end
    lock = 1'b0;
    step(1);
    hand("t4_unlock", 2'd2, 1'b1);

    // request drop with nothing pending goes idle and keeps SEL
    do_reset();
    req = 4'b1000;
    step(1);
    hand("t5_g3", 2'd3, 1'b1);
    req = 4'b0000;
    step(1);
    hand("t5_drop", 2'd3, 1'b0);
    step(2);
    req = 4'b1000;
    step(1);
    hand("t5_regrant", 2'd3, 1'b1);

    // reset mid-grant, then EN low mid-grant
    do_reset();
    req = 4'b0100;
    step(1);
    hand("t6_g2", 2'd2, 1'b1);
    rst_n = 1'b0;
    step(1);
    hand("t6_rst", 2'd0, 1'b0);
    rst_n = 1'b1; req = 4'b1111;
    step(1);
    hand("t6_after_rst", 2'd0, 1'b1);
    do_reset();
    req = 4'b0100;
    step(1);
    hand("t6_g2b", 2'd2, 1'b1);
    en = 1'b0;
    step(1);
    hand("t6_en_low", 2'd2, 1'b0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
